// File: rtl/uart_rx_cfg.sv
// Parametrised oversampling UART receiver: 2-FF synchroniser, 3-sample majority vote,
// optional parity, 1/2 stop bits and a valid/ready output holding register.
module uart_rx_cfg #(
    parameter int DATA_BITS  = 7,
    parameter int OVERSAMPLE = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 rx,
    input  logic                 ready_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid_out,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic [2:0]           state_out
);

    localparam int MID   = OVERSAMPLE / 2;
    localparam int CNT_W = $clog2(OVERSAMPLE);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(MID - 1);
    localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(MID);
    localparam logic [CNT_W-1:0] CNT_S2   = CNT_W'(MID + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [3:0]       BIT_LAST = 4'(DATA_BITS - 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2);
    localparam logic             PAR_ODD   = (PARITY_ODD != 0);
    localparam logic             PAR_USED  = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    logic                 rx_meta_q, rx_s_q;
    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic                 samp0_q, samp0_d;
    logic                 samp1_q, samp1_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 fe_pend_q, fe_pend_d;
    logic                 pe_pend_q, pe_pend_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 overrun_q, overrun_d;
    logic                 commit;
    logic                 vote;
    logic                 par_exp;
    logic                 at_s2, at_last;

    // The synchroniser runs every clock; ena only paces the bit-level logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Third sample is the live synchronised line, so the vote resolves at MID+1.
    assign vote    = (samp0_q & samp1_q) | (samp0_q & rx_s_q) | (samp1_q & rx_s_q);
    assign par_exp = (^shift_q) ^ PAR_ODD;
    assign at_s2   = (cnt_q == CNT_S2);
    assign at_last = (cnt_q == CNT_LAST);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        stop_d       = stop_q;
        samp0_d      = samp0_q;
        samp1_d      = samp1_q;
        shift_d      = shift_q;
        fe_pend_d    = fe_pend_q;
        pe_pend_d    = pe_pend_q;
        data_d       = data_q;
        valid_d      = valid_q;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;
        overrun_d    = 1'b0;
        commit       = 1'b0;

        if (valid_q && ready_in) begin
            valid_d = 1'b0;
        end

        if (ena) begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == CNT_S0) begin
                samp0_d = rx_s_q;
            end
            if (cnt_q == CNT_S1) begin
                samp1_d = rx_s_q;
            end

            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        state_d   = S_START;
                        cnt_d     = CNT_ONE;
                        fe_pend_d = 1'b0;
                        pe_pend_d = 1'b0;
                    end
                end
                S_START: begin
                    if (at_s2 && vote) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (at_last) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                        bit_d   = '0;
                    end
                end
                S_DATA: begin
                    if (at_s2) begin
                        shift_d = {vote, shift_q[DATA_BITS-1:1]};
                    end
                    if (at_last) begin
                        cnt_d = '0;
                        if (bit_q == BIT_LAST) begin
                            state_d = PAR_USED ? S_PARITY : S_STOP;
                            stop_d  = 1'b0;
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (at_s2 && (vote != par_exp)) begin
                        pe_pend_d = 1'b1;
                    end
                    if (at_last) begin
                        state_d = S_STOP;
                        cnt_d   = '0;
                        stop_d  = 1'b0;
                    end
                end
                S_STOP: begin
                    if (at_s2) begin
                        if (!vote) begin
                            fe_pend_d = 1'b1;
                        end
                        // Leaving at mid-bit of the last stop lets the next start edge be caught.
                        if (stop_q == STOP_LAST) begin
                            commit  = 1'b1;
                            state_d = S_IDLE;
                            cnt_d   = '0;
                        end
                    end
                    if (at_last && !commit) begin
                        cnt_d  = '0;
                        stop_d = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase

            if (commit) begin
                if (!valid_q || ready_in) begin
                    data_d       = shift_q;
                    frame_err_d  = fe_pend_q | ~vote;
                    parity_err_d = pe_pend_q;
                    valid_d      = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            stop_q       <= 1'b0;
            samp0_q      <= 1'b0;
            samp1_q      <= 1'b0;
            shift_q      <= '0;
            fe_pend_q    <= 1'b0;
            pe_pend_q    <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            stop_q       <= stop_d;
            samp0_q      <= samp0_d;
            samp1_q      <= samp1_d;
            shift_q      <= shift_d;
            fe_pend_q    <= fe_pend_d;
            pe_pend_q    <= pe_pend_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign data_out   = data_q;
    assign valid_out  = valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;
    assign state_out  = state_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: four instances cover default, odd-parity 8-bit,
// two-stop-bit and 16x oversampling configurations.
module tb_uart_rx_cfg;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       ena      = 1'b0;
    logic       ready_in = 1'b0;
    logic [3:0] rx       = 4'hF;

    logic [6:0] dout0, dout2, dout3;
    logic [7:0] dout1;
    logic [3:0] valid, ferr, perr, ovr;
    logic [2:0] st0, st1, st2, st3;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int         riseCnt [4] = '{default: 0};
    int         ovCnt   [4] = '{default: 0};
    int         riseCyc [4] = '{default: 0};
    logic [8:0] capData [4] = '{default: '0};
    logic       capFe   [4] = '{default: 1'b0};
    logic       capPe   [4] = '{default: 1'b0};
    logic [8:0] doutW   [4];
    logic [3:0] validPrev = 4'h0;

    uart_rx_cfg dut0 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .rx(rx[0]), .ready_in(ready_in),
        .data_out(dout0), .valid_out(valid[0]), .frame_err(ferr[0]),
        .parity_err(perr[0]), .overrun(ovr[0]), .state_out(st0)
    );

    uart_rx_cfg #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .rx(rx[1]), .ready_in(ready_in),
        .data_out(dout1), .valid_out(valid[1]), .frame_err(ferr[1]),
        .parity_err(perr[1]), .overrun(ovr[1]), .state_out(st1)
    );

    uart_rx_cfg #(.STOP_BITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .rx(rx[2]), .ready_in(ready_in),
        .data_out(dout2), .valid_out(valid[2]), .frame_err(ferr[2]),
        .parity_err(perr[2]), .overrun(ovr[2]), .state_out(st2)
    );

    uart_rx_cfg #(.OVERSAMPLE(16)) dut3 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .rx(rx[3]), .ready_in(ready_in),
        .data_out(dout3), .valid_out(valid[3]), .frame_err(ferr[3]),
        .parity_err(perr[3]), .overrun(ovr[3]), .state_out(st3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        doutW[0] = {2'b00, dout0};
        doutW[1] = {1'b0, dout1};
        doutW[2] = {2'b00, dout2};
        doutW[3] = {2'b00, dout3};
    end

    // Latch each delivered frame at the rising edge of valid_out, and count overrun cycles.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (valid[i] && !validPrev[i]) begin
                riseCnt[i] <= riseCnt[i] + 1;
                riseCyc[i] <= cyc;
                capData[i] <= doutW[i];
                capFe[i]   <= ferr[i];
                capPe[i]   <= perr[i];
            end
            if (ovr[i]) begin
                ovCnt[i] <= ovCnt[i] + 1;
            end
            validPrev[i] <= valid[i];
        end
    end

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame on rx[inst], starting at a falling clock edge; returns the start cycle.
    task automatic applyStimulus(input int inst, input logic [8:0] data, input int nbits,
                                 input int os, input bit parEn, input bit parBit,
                                 input bit stop0, input bit stop1, input int nstop,
                                 output int startCyc);
        rx[inst] = 1'b0;
        startCyc = cyc;
        repeat (os) @(negedge clk);
        for (int b = 0; b < nbits; b++) begin
            rx[inst] = data[b];
            repeat (os) @(negedge clk);
        end
        if (parEn) begin
            rx[inst] = parBit;
            repeat (os) @(negedge clk);
        end
        rx[inst] = stop0;
        repeat (os) @(negedge clk);
        if (nstop == 2) begin
            rx[inst] = stop1;
            repeat (os) @(negedge clk);
        end
        rx[inst] = 1'b1;
    endtask

    initial begin
        int s;
        int r0;
        int ov0;

        idle(3);
        checkOutput("reset_state", {4'h0, st0, st1, st2, st3}, 16'h0000);
        checkOutput("reset_valid", {12'h000, valid}, 16'h0000);
        checkOutput("reset_data", {dout0, 1'b0, dout1}, 16'h0000);
        checkOutput("reset_flags", {4'h0, ferr, perr, ovr}, 16'h0000);

        rst_n    = 1'b1;
        ena      = 1'b1;
        ready_in = 1'b1;
        idle(4);

        // Clean default frame
        r0 = riseCnt[0];
        applyStimulus(0, 9'h05A, 7, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, s);
        idle(4);
        checkOutput("t1_frames", 16'(riseCnt[0] - r0), 16'd1);
        checkOutput("t1_data", {7'h0, capData[0]}, 16'h005A);
        checkOutput("t1_latency", 16'(riseCyc[0] - s), 16'd72);
        checkOutput("t1_flags", {14'h0, capFe[0], capPe[0]}, 16'h0000);
        checkOutput("t1_valid_drop", {15'h0, valid[0]}, 16'h0000);
        checkOutput("t1_hold", {9'h0, dout0}, 16'h005A);

        // Start glitch: two clocks low
        r0 = riseCnt[0];
        rx[0] = 1'b0;
        idle(2);
        rx[0] = 1'b1;
        idle(1);
        checkOutput("glitch_start", {13'h0, st0}, 16'd1);
        idle(12);
        checkOutput("glitch_idle", {13'h0, st0}, 16'd0);
        checkOutput("glitch_no_frame", 16'(riseCnt[0] - r0), 16'd0);

        // Odd parity, wrong parity bit then correct one
        applyStimulus(1, 9'h0A5, 8, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1, s);
        idle(4);
        checkOutput("par_data", {7'h0, capData[1]}, 16'h00A5);
        checkOutput("par_err", {15'h0, capPe[1]}, 16'h0001);
        checkOutput("par_fe", {15'h0, capFe[1]}, 16'h0000);
        checkOutput("par_latency", 16'(riseCyc[1] - s), 16'd88);
        applyStimulus(1, 9'h03C, 8, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1, s);
        idle(4);
        checkOutput("par_ok_data", {7'h0, capData[1]}, 16'h003C);
        checkOutput("par_ok_flag", {15'h0, capPe[1]}, 16'h0000);

        // Framing error then clean frame
        r0 = riseCnt[0];
        applyStimulus(0, 9'h033, 7, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1, s);
        idle(16);
        checkOutput("fe_data", {7'h0, capData[0]}, 16'h0033);
        checkOutput("fe_flag", {15'h0, capFe[0]}, 16'h0001);
        checkOutput("fe_frames", 16'(riseCnt[0] - r0), 16'd1);
        applyStimulus(0, 9'h011, 7, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, s);
        idle(4);
        checkOutput("fe_next_data", {7'h0, capData[0]}, 16'h0011);
        checkOutput("fe_next_flags", {14'h0, capFe[0], capPe[0]}, 16'h0000);

        // Overrun: consumer stalled over two back-to-back frames
        ready_in = 1'b0;
        r0  = riseCnt[0];
        ov0 = ovCnt[0];
        applyStimulus(0, 9'h001, 7, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, s);
        applyStimulus(0, 9'h002, 7, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, s);
        idle(4);
        checkOutput("ovr_frames", 16'(riseCnt[0] - r0), 16'd1);
        checkOutput("ovr_pulses", 16'(ovCnt[0] - ov0), 16'd1);
        checkOutput("ovr_hold_data", {9'h0, dout0}, 16'h0001);
        checkOutput("ovr_hold_valid", {15'h0, valid[0]}, 16'h0001);
        ena      = 1'b0;
        ready_in = 1'b1;
        idle(1);
        checkOutput("ena0_handshake", {15'h0, valid[0]}, 16'h0000);
        checkOutput("ena0_data_hold", {9'h0, dout0}, 16'h0001);
        ena = 1'b1;
        idle(4);

        // Reset in the middle of the data bits
        r0 = riseCnt[0];
        rx[0] = 1'b0;
        idle(8);
        rx[0] = 1'b1;
        idle(8);
        rx[0] = 1'b0;
        idle(8);
        checkOutput("mid_data_state", {13'h0, st0}, 16'd2);
        rst_n = 1'b0;
        idle(2);
        checkOutput("rst_state", {13'h0, st0}, 16'd0);
        checkOutput("rst_outputs", {dout0, valid[0], ferr[0], perr[0], ovr[0]}, 16'h0000);
        rx[0] = 1'b1;
        rst_n = 1'b1;
        idle(8);
        checkOutput("rst_no_commit", 16'(riseCnt[0] - r0), 16'd0);
        applyStimulus(0, 9'h07F, 7, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, s);
        idle(4);
        checkOutput("rst_next_frames", 16'(riseCnt[0] - r0), 16'd1);
        checkOutput("rst_next_data", {7'h0, capData[0]}, 16'h007F);

        // Two stop bits
        applyStimulus(2, 9'h05A, 7, 8, 1'b0, 1'b0, 1'b1, 1'b1, 2, s);
        idle(4);
        checkOutput("s2_data", {7'h0, capData[2]}, 16'h005A);
        checkOutput("s2_latency", 16'(riseCyc[2] - s), 16'd80);
        checkOutput("s2_fe", {15'h0, capFe[2]}, 16'h0000);
        applyStimulus(2, 9'h02B, 7, 8, 1'b0, 1'b0, 1'b1, 1'b0, 2, s);
        idle(16);
        checkOutput("s2_bad_data", {7'h0, capData[2]}, 16'h002B);
        checkOutput("s2_bad_fe", {15'h0, capFe[2]}, 16'h0001);

        // 16x oversampling
        applyStimulus(3, 9'h02C, 7, 16, 1'b0, 1'b0, 1'b1, 1'b1, 1, s);
        idle(4);
        checkOutput("os16_data", {7'h0, capData[3]}, 16'h002C);
        checkOutput("os16_latency", 16'(riseCyc[3] - s), 16'd140);
        checkOutput("os16_flags", {14'h0, capFe[3], capPe[3]}, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
